// File: rtl/alu_mem_ctrl.sv
// Sequences one ALU command through a memory-mapped register file: writes operands,
// opcode and the exec bit, waits for completion (with timeout), then reads the result.
module alu_mem_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int RES_REG    = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [DATA_WIDTH-1:0] cmd_a_i,
  input  logic [DATA_WIDTH-1:0] cmd_b_i,
  input  logic [2:0]            cmd_op_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic                  mem_enable_o,
  output logic                  mem_rd_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  input  logic                  alu_done_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_WR_B, S_WR_OP, S_WR_EXEC, S_WAIT,
    S_CLR_EXEC, S_RD_REQ, S_RD_W1, S_RD_W2, S_RESP
  } state_t;

  localparam logic [DATA_WIDTH-1:0] EXEC_WORD = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [8:0]            cnt_inc;
  logic                  expired;

  // One extra bit so the compare stays correct when TIMEOUT is 255.
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign expired = (cnt_inc >= 9'(TIMEOUT));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          a_d     = cmd_a_i;
          b_d     = cmd_b_i;
          op_d    = cmd_op_i;
          state_d = S_WR_A;
        end
      end
      S_WR_A:    state_d = S_WR_B;
      S_WR_B:    state_d = S_WR_OP;
      S_WR_OP:   state_d = S_WR_EXEC;
      S_WR_EXEC: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc[7:0];
        // Completion takes priority over a timeout landing in the same cycle.
        if (alu_done_i) begin
          err_d   = 1'b0;
          state_d = S_CLR_EXEC;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_CLR_EXEC;
        end
      end
      S_CLR_EXEC: begin
        if (err_q) begin
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: state_d = S_RD_W1;
      S_RD_W1:  state_d = S_RD_W2;
      S_RD_W2: begin
        rsp_data_d = mem_rd_data_i;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus strobe decode; every non-bus state parks the bus at enable=0, read, addr 0, data 0.
  always_comb begin
    mem_enable_o  = 1'b0;
    mem_rd_wr_o   = 1'b1;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    case (state_q)
      S_WR_A: begin
        mem_enable_o  = 1'b1;
        mem_rd_wr_o   = 1'b0;
        mem_addr_o    = ADDR_WIDTH'(0);
        mem_wr_data_o = a_q;
      end
      S_WR_B: begin
        mem_enable_o  = 1'b1;
        mem_rd_wr_o   = 1'b0;
        mem_addr_o    = ADDR_WIDTH'(1);
        mem_wr_data_o = b_q;
      end
      S_WR_OP: begin
        mem_enable_o  = 1'b1;
        mem_rd_wr_o   = 1'b0;
        mem_addr_o    = ADDR_WIDTH'(2);
        mem_wr_data_o = {op_q, {(DATA_WIDTH-3){1'b0}}};
      end
      S_WR_EXEC: begin
        mem_enable_o  = 1'b1;
        mem_rd_wr_o   = 1'b0;
        mem_addr_o    = ADDR_WIDTH'(3);
        mem_wr_data_o = EXEC_WORD;
      end
      S_CLR_EXEC: begin
        mem_enable_o  = 1'b1;
        mem_rd_wr_o   = 1'b0;
        mem_addr_o    = ADDR_WIDTH'(3);
      end
      S_RD_REQ: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = ADDR_WIDTH'(RES_REG);
      end
      default: ;
    endcase
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_mem_ctrl.sv
// Self-checking bench for alu_mem_ctrl: register-file/ALU bus model plus timeline-level
// expectations for latency, response and the sequence of bus accesses.
`timescale 1ns/1ps
module tb_alu_mem_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int RES = 4;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic rsp_err, busy, mem_enable, mem_rd_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic alu_done = 1'b0;

  always #5 clk = ~clk;

  alu_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RES_REG(RES), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .busy_o(busy),
    .mem_enable_o(mem_enable), .mem_rd_wr_o(mem_rd_wr),
    .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data),
    .mem_rd_data_i(mem_rd_data), .alu_done_i(alu_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Register file + ALU model state
  logic [DW-1:0] regfile [8];
  int unsigned bus_sig = 0;
  int bus_cnt = 0;
  int idle_bad = 0;
  bit exec_active = 0;
  int wcnt = 0;
  int alu_dly = 0;
  logic [DW-1:0] s1 = '0, s2 = '0;

  function automatic int unsigned sig_add(int unsigned s, bit rw, int addr, int data);
    return s * 32'd33 + 32'(rw) * 32'd4096 + 32'(addr) * 32'd256 + 32'(data);
  endfunction

  // Expected bus history: a@0, b@1, op<<5 @2, exec set @3, exec clear @3, read @RES unless timed out.
  function automatic int unsigned model_sig(logic [7:0] a, logic [7:0] b, logic [2:0] op, bit tmo);
    int unsigned s;
    logic [7:0] opw;
    opw = {op, 5'b0};
    s = 0;
    s = sig_add(s, 1'b0, 0, int'(a));
    s = sig_add(s, 1'b0, 1, int'(b));
    s = sig_add(s, 1'b0, 2, int'(opw));
    s = sig_add(s, 1'b0, 3, 8'h80);
    s = sig_add(s, 1'b0, 3, 0);
    if (!tmo) s = sig_add(s, 1'b1, RES, 0);
    return s;
  endfunction

  // Bus/ALU model: drives inputs and observes the bus on the falling edge.
  // Read data appears two cycles after the request and is garbage otherwise.
  always @(negedge clk) begin
    mem_rd_data = s2;
    s2 = s1;
    s1 = 8'($urandom);
    if (exec_active) begin
      wcnt++;
      alu_done = (alu_dly > 0) && (wcnt >= alu_dly);
    end
    if (mem_enable === 1'b1) begin
      bus_cnt++;
      if (mem_rd_wr === 1'b1) begin
        s1 = regfile[mem_addr];
        bus_sig = sig_add(bus_sig, 1'b1, int'(mem_addr), 0);
      end else begin
        regfile[mem_addr] = mem_wr_data;
        bus_sig = sig_add(bus_sig, 1'b0, int'(mem_addr), int'(mem_wr_data));
        if (mem_addr == 3'd3 && mem_wr_data == 8'h80) begin
          exec_active = 1; wcnt = 0; alu_done = 1'b0;
        end else if (mem_addr == 3'd3 && mem_wr_data == 8'h00) begin
          exec_active = 0;
        end
      end
    end else if (mem_rd_wr !== 1'b1 || mem_addr !== '0 || mem_wr_data !== '0) begin
      idle_bad++;
    end
    if (!exec_active) alu_done = 1'($urandom_range(0, 1));
  end

  // Runs one command starting at a falling edge; returns at the falling edge of the first
  // RESP cycle (ack=0) or of the cycle after the handshake (ack=1).
  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input int dly, input logic [7:0] res, input bit ack,
                        output int wait_cyc, output int lat, output logic [7:0] data, output logic err);
    regfile[RES] = res;
    alu_dly = dly;
    bus_sig = 0;
    bus_cnt = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    wait_cyc = 0;
    while (cmd_ready !== 1'b1 && wait_cyc < 50) begin @(negedge clk); wait_cyc++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    data = rsp_data;
    err = rsp_err;
    if (ack) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  logic [24:0] rst_exp;
  function automatic logic [24:0] out_vec();
    return {cmd_ready, rsp_valid, rsp_data, rsp_err, busy, mem_enable, mem_rd_wr, mem_addr, mem_wr_data};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_vec() !== rst_exp) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", out_vec(), rst_exp);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_vec() !== rst_exp) begin
      n_fail++; $display("FAIL idle_after_reset: got %h expected %h", out_vec(), rst_exp);
    end
    $display("test_reset done");
  endtask

  // Directed rows: normal, timeout, done on the expiry cycle, done one before expiry.
  task automatic test_directed();
    logic [7:0] ta [4] = '{8'h05, 8'h3C, 8'hA7, 8'h11};
    logic [7:0] tb [4] = '{8'h03, 8'hC3, 8'h5A, 8'h22};
    logic [2:0] top [4] = '{3'b010, 3'b111, 3'b001, 3'b100};
    int tdly [4] = '{1, 0, 15, 14};
    logic [7:0] tres [4] = '{8'h08, 8'h77, 8'h9E, 8'h00};
    int tlat [4] = '{10, 21, 24, 23};
    logic [7:0] tdata [4] = '{8'h08, 8'hFF, 8'h9E, 8'h00};
    logic terr [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int tcnt [4] = '{6, 5, 6, 6};
    int wc, lat;
    logic [7:0] d;
    logic e;
    for (int i = 0; i < 4; i++) begin
      do_txn(ta[i], tb[i], top[i], tdly[i], tres[i], 1'b1, wc, lat, d, e);
      $display("directed %0d: a=%h b=%h op=%0d lat=%0d data=%h err=%0d", i, ta[i], tb[i], top[i], lat, d, e);
      n_checks++;
      if (lat !== tlat[i]) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, tlat[i]); end
      n_checks++;
      if (d !== tdata[i] || e !== terr[i]) begin
        n_fail++; $display("FAIL dir%0d_rsp: got %h/%0d expected %h/%0d", i, d, e, tdata[i], terr[i]);
      end
      n_checks++;
      if (bus_cnt !== tcnt[i] || bus_sig !== model_sig(ta[i], tb[i], top[i], terr[i])) begin
        n_fail++; $display("FAIL dir%0d_bus: got cnt %0d sig %h expected cnt %0d sig %h", i, bus_cnt, bus_sig,
                           tcnt[i], model_sig(ta[i], tb[i], top[i], terr[i]));
      end
    end
    n_checks++;
    if (idle_bad !== 0) begin n_fail++; $display("FAIL idle_bus: got %0d bad cycles expected 0", idle_bad); end
  endtask

  task automatic test_backpressure();
    int wc, lat, cnt0;
    logic [7:0] d;
    logic e;
    do_txn(8'h21, 8'h43, 3'b011, 3, 8'h5D, 1'b0, wc, lat, d, e);
    cnt0 = bus_cnt;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_a = 8'($urandom);
      @(negedge clk);
      $display("backpressure cycle %0d: rsp_valid=%0d data=%h err=%0d cmd_ready=%0d", i, rsp_valid, rsp_data, rsp_err, cmd_ready);
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_err, cmd_ready, busy} !== {1'b1, 8'h5D, 1'b0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL stall%0d: got v=%0d d=%h e=%0d rdy=%0d expected v=1 d=5d e=0 rdy=0",
                           i, rsp_valid, rsp_data, rsp_err, cmd_ready);
      end
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010 || bus_cnt !== cnt0) begin
      n_fail++; $display("FAIL release: got v=%0d rdy=%0d busy=%0d bus %0d expected v=0 rdy=1 busy=0 bus %0d",
                         rsp_valid, cmd_ready, busy, bus_cnt, cnt0);
    end
  endtask

  // Asynchronous reset pulse in cycle k after accept (3=WR_OP, 5=WAIT, 8=RD_W1).
  task automatic test_reset_midop();
    int ks [3] = '{3, 5, 8};
    logic ens [3] = '{1'b1, 1'b0, 1'b0};
    int wc, lat, cnt0;
    logic [7:0] d;
    logic e;
    for (int i = 0; i < 3; i++) begin
      regfile[RES] = 8'hC4;
      alu_dly = (ks[i] == 8) ? 1 : 0;
      cmd_a = 8'h9A; cmd_b = 8'h1B; cmd_op = 3'b110; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (ks[i] - 1) @(posedge clk);
      #2;
      n_checks++;
      if (busy !== 1'b1 || mem_enable !== ens[i]) begin
        n_fail++; $display("FAIL pre_reset%0d: got busy=%0d en=%0d expected busy=1 en=%0d", ks[i], busy, mem_enable, ens[i]);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (out_vec() !== rst_exp) begin
        n_fail++; $display("FAIL midop_reset%0d: got %h expected %h", ks[i], out_vec(), rst_exp);
      end
      @(negedge clk);
      reset = 1'b0;
      cnt0 = bus_cnt;
      repeat (20) @(negedge clk);
      n_checks++;
      if (bus_cnt !== cnt0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL post_reset%0d: got bus %0d busy %0d expected bus %0d busy 0", ks[i], bus_cnt, busy, cnt0);
      end
      do_txn(8'h0F, 8'hF0, 3'b101, 2, 8'h3E, 1'b1, wc, lat, d, e);
      $display("after reset in cycle %0d: lat=%0d data=%h err=%0d", ks[i], lat, d, e);
      n_checks++;
      if (lat !== 11 || d !== 8'h3E || e !== 1'b0 || bus_sig !== model_sig(8'h0F, 8'hF0, 3'b101, 1'b0)) begin
        n_fail++; $display("FAIL recover%0d: got lat %0d data %h err %0d expected lat 11 data 3e err 0", ks[i], lat, d, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int wc, lat;
    logic [7:0] d;
    logic e;
    rsp_ready = 1'b1;
    do_txn(8'h12, 8'h34, 3'b000, 1, 8'h46, 1'b0, wc, lat, d, e);
    @(negedge clk);
    n_checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_idle: got rdy=%0d v=%0d expected rdy=1 v=0", cmd_ready, rsp_valid);
    end
    do_txn(8'h56, 8'h78, 3'b011, 4, 8'hCE, 1'b0, wc, lat, d, e);
    $display("back_to_back second: wait=%0d lat=%0d data=%h err=%0d bus=%0d", wc, lat, d, e, bus_cnt);
    n_checks++;
    if (wc !== 0 || lat !== 13 || d !== 8'hCE || e !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got wait %0d lat %0d data %h err %0d expected 0 13 ce 0", wc, lat, d, e);
    end
    n_checks++;
    if (bus_cnt !== 6 || bus_sig !== model_sig(8'h56, 8'h78, 3'b011, 1'b0)) begin
      n_fail++; $display("FAIL b2b_bus: got cnt %0d sig %h expected cnt 6 sig %h", bus_cnt, bus_sig, model_sig(8'h56, 8'h78, 3'b011, 1'b0));
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    int wc, lat, dly, exp_lat, exp_cnt;
    logic [7:0] a, b, res, d, exp_d;
    logic [2:0] op;
    logic e;
    bit tmo;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); res = 8'($urandom);
      dly = $urandom_range(0, 18);
      tmo = (dly == 0) || (dly > TO);
      exp_lat = tmo ? (5 + TO + 1) : (9 + dly);
      exp_d = tmo ? 8'hFF : res;
      exp_cnt = tmo ? 5 : 6;
      do_txn(a, b, op, dly, res, 1'b1, wc, lat, d, e);
      $display("random %0d: a=%h b=%h op=%0d dly=%0d lat=%0d data=%h err=%0d", i, a, b, op, dly, lat, d, e);
      n_checks++;
      if (lat !== exp_lat || d !== exp_d || e !== tmo) begin
        n_fail++; $display("FAIL rand%0d_rsp: got lat %0d data %h err %0d expected lat %0d data %h err %0d",
                           i, lat, d, e, exp_lat, exp_d, tmo);
      end
      n_checks++;
      if (bus_cnt !== exp_cnt || bus_sig !== model_sig(a, b, op, tmo)) begin
        n_fail++; $display("FAIL rand%0d_bus: got cnt %0d sig %h expected cnt %0d sig %h",
                           i, bus_cnt, bus_sig, exp_cnt, model_sig(a, b, op, tmo));
      end
    end
    n_checks++;
    if (idle_bad !== 0) begin n_fail++; $display("FAIL idle_bus_final: got %0d bad cycles expected 0", idle_bad); end
  endtask

  initial begin
    rst_exp = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00};
    for (int i = 0; i < 8; i++) regfile[i] = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_mem_ctrl.md
ALU_MEM_CTRL -- requirements
Module: alu_mem_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of register file words and operands.
REQ-002 Parameter ADDR_WIDTH, default 3, register file address width.
REQ-003 Parameter RES_REG, default 4, register file address holding ALU result.
REQ-004 Parameter TIMEOUT, default 15, max cycles waiting for alu_done (range 1..255).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid / cmd_ready  in / out  1  command handshake.
REQ-008 cmd_a, cmd_b  in  DATA_WIDTH  operands; cmd_op  in  3  ALU opcode.
REQ-009 rsp_valid / rsp_ready  out / in  1  response handshake.
REQ-010 rsp_data  out  DATA_WIDTH  result; rsp_err  out  1  timeout flag.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 mem_enable, mem_rd_wr  out  1  register-file bus strobe; rd_wr 0 = write, 1 = read.
REQ-013 mem_addr  out  ADDR_WIDTH; mem_wr_data  out  DATA_WIDTH; mem_rd_data  in  DATA_WIDTH.
REQ-014 alu_done  in  1  ALU completion pulse/level.

Function
REQ-015 States: IDLE, WR_A, WR_B, WR_OP, WR_EXEC, WAIT, CLR_EXEC, RD_REQ, RD_W1, RD_W2, RESP.
REQ-016 cmd_ready SHALL be 1 only in IDLE; cmd_valid&cmd_ready captures a, b, op and moves to WR_A.
REQ-017 WR_A/WR_B/WR_OP/WR_EXEC/CLR_EXEC: one cycle each, mem_enable=1, mem_rd_wr=0, addr 0/1/2/3/3.
REQ-018 Write data: WR_A=a, WR_B=b; WR_OP places op in the 3 MSBs (bits W-1..W-3), others 0.
REQ-019 WR_EXEC data = MSB 1, rest 0; CLR_EXEC data = all 0.
REQ-020 WAIT: mem_enable=0; 8-bit counter cleared on entry, increments each WAIT cycle.
REQ-021 alu_done high in WAIT -> CLR_EXEC, error flag 0; done wins over simultaneous timeout.
REQ-022 Counter reaching TIMEOUT without done -> CLR_EXEC with error flag 1.
REQ-023 After CLR_EXEC: error 0 -> RD_REQ; error 1 -> RESP with rsp_data all ones, rsp_err 1.
REQ-024 RD_REQ: one cycle, mem_enable=1, mem_rd_wr=1, mem_addr=RES_REG; then RD_W1, RD_W2.
REQ-025 Read latency 2: mem_rd_data captured into rsp_data at end of RD_W2; then RESP, rsp_err 0.
REQ-026 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready; handshake -> IDLE.
REQ-027 Outside write/read states: mem_enable=0, mem_rd_wr=1, mem_addr=0, mem_wr_data=0.
REQ-028 cmd_valid outside IDLE SHALL be ignored; no queuing.
REQ-029 alu_done outside WAIT SHALL be ignored.

Reset
REQ-030 reset asserted -> state IDLE immediately, independent of clk, mid-operation included.
REQ-031 Reset values: cmd_ready 1, rsp_valid 0, rsp_data 0, rsp_err 0, busy 0, mem_enable 0, mem_rd_wr 1, mem_addr 0, mem_wr_data 0, counter 0.
REQ-032 Reset during WAIT SHALL NOT issue CLR_EXEC; register file reset is the mem block's job.

Verification
REQ-033 a=0x05,b=0x03,op=3'b010, alu_done in first WAIT cycle, mem returns 0x08 -> writes 0x05@0,0x03@1,0x40@2,0x80@3,0x00@3, read @4, rsp_valid 10 cycles after accept, rsp_data 0x08, rsp_err 0.
REQ-034 No alu_done, TIMEOUT=15 -> CLR_EXEC write 0x00@3, no read, rsp_valid 21 cycles after accept, rsp_data 0xFF, rsp_err 1.
REQ-035 alu_done on the 15th WAIT cycle (same as expiry) -> normal read path, rsp_err 0.
REQ-036 rsp_ready held low 5 cycles in RESP -> rsp_valid/data stable, cmd_ready 0, cmd_valid ignored; releases to IDLE on handshake.
REQ-037 reset pulsed during WR_OP and during RD_W1 -> outputs at reset values same cycle; next command completes normally.
REQ-038 Back-to-back commands with rsp_ready tied 1 -> second accepted the cycle after RESP, no bus overlap.
